// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C slave receive/transmit block.
// The FSM state encoding and the bus-level bit meanings live here.
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WR_DATA,
        ST_WR_ACK,
        ST_RD_DATA,
        ST_RD_ACK,
        ST_WAIT_STOP
    } i2c_state_e;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;
    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_slave_rx_tx_if.sv
// Pad-side I2C signals: raw SCL/SDA in, open-drain SDA pull-down enable out.
interface i2c_slave_rx_tx_if;

    logic scl_in;
    logic sda_in;
    logic sda_oe;

    modport slave  (input scl_in, input sda_in, output sda_oe);
    modport master (output scl_in, output sda_in, input sda_oe);

endinterface

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchroniser plus edge and START/STOP detector.
// Events are combinational from the last sync stage and its registered copy.
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl_s,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic                   scl_prev_q;
    logic                   sda_prev_q;

    // Idle bus is high, so resetting to 1 cannot fabricate an event.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_in};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
        end
    end

    assign scl_s     = scl_sync_q[SYNC_STAGES-1];
    assign sda_s     = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s & scl_prev_q;
    assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

endmodule

// File: rtl/i2c_slave_rx_tx.sv
// Oversampled I2C slave: 7-bit address match, buffered write bytes with
// per-byte ACK control, and a NUM_BYTES read payload.
module i2c_slave_rx_tx
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR  = 7'h5B,
    parameter int         NUM_BYTES   = 2,
    parameter int         SYNC_STAGES = 2,
    localparam int        CNT_W       = $clog2(NUM_BYTES + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    i2c_slave_rx_tx_if.slave       bus,
    input  logic [NUM_BYTES-1:0]   ack_en,
    input  logic [8*NUM_BYTES-1:0] tx_data,
    output logic [8*NUM_BYTES-1:0] rx_data,
    output logic [CNT_W-1:0]       rx_count,
    output logic                   rx_valid,
    output logic                   busy,
    output logic                   overflow
);

    localparam logic [CNT_W-1:0] NUM_BYTES_C = CNT_W'(NUM_BYTES);

    logic scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;

    i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .scl_in    (bus.scl_in),
        .sda_in    (bus.sda_in),
        .scl_s     (scl_s),
        .sda_s     (sda_s),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    i2c_state_e             state_q, state_d;
    logic [3:0]             bit_cnt_q, bit_cnt_d;
    logic [6:0]             shift_q, shift_d;
    logic                   rw_q, rw_d;
    logic                   phase_q, phase_d;
    logic                   ack_drv_q, ack_drv_d;
    logic                   wr_xfer_q, wr_xfer_d;
    logic [CNT_W-1:0]       rd_idx_q, rd_idx_d;
    logic                   sda_oe_q, sda_oe_d;
    logic [8*NUM_BYTES-1:0] rx_data_q, rx_data_d;
    logic [CNT_W-1:0]       rx_count_q, rx_count_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   busy_q, busy_d;
    logic                   overflow_q, overflow_d;

    logic [7:0]             new_byte;
    logic [7:0]             tx_byte;
    logic [NUM_BYTES-1:0]   wr_hit, rd_hit;
    logic                   ack_sel, wr_in_range, drive_edge;

    assign new_byte = {shift_q, sda_s};

    for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_lane
        assign wr_hit[gi] = (rx_count_q == CNT_W'(gi));
        assign rd_hit[gi] = (rd_idx_q == CNT_W'(gi));
    end

    // Read indices past the buffer fall through to all-ones, i.e. SDA released.
    always_comb begin
        tx_byte = 8'hFF;
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (rd_hit[i]) tx_byte = tx_data[8*i +: 8];
        end
    end

    assign ack_sel     = |(wr_hit & ack_en);
    assign wr_in_range = (rx_count_q < NUM_BYTES_C);
    assign drive_edge  = scl_fall & ~scl_s;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            rw_q       <= RW_WRITE;
            phase_q    <= 1'b0;
            ack_drv_q  <= 1'b0;
            wr_xfer_q  <= 1'b0;
            rd_idx_q   <= '0;
            sda_oe_q   <= 1'b0;
            rx_data_q  <= '0;
            rx_count_q <= '0;
            rx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            rw_q       <= rw_d;
            phase_q    <= phase_d;
            ack_drv_q  <= ack_drv_d;
            wr_xfer_q  <= wr_xfer_d;
            rd_idx_q   <= rd_idx_d;
            sda_oe_q   <= sda_oe_d;
            rx_data_q  <= rx_data_d;
            rx_count_q <= rx_count_d;
            rx_valid_q <= rx_valid_d;
            busy_q     <= busy_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        rw_d       = rw_q;
        phase_d    = phase_q;
        ack_drv_d  = ack_drv_q;
        wr_xfer_d  = wr_xfer_q;
        rd_idx_d   = rd_idx_q;
        sda_oe_d   = sda_oe_q;
        rx_data_d  = rx_data_q;
        rx_count_d = rx_count_q;
        rx_valid_d = 1'b0;
        busy_d     = busy_q;
        overflow_d = overflow_q;

        // A repeated START closes the transfer exactly like a STOP first.
        if (start_det || stop_det) begin
            rx_valid_d = wr_xfer_q && (rx_count_q != '0);
            busy_d     = 1'b0;
            sda_oe_d   = 1'b0;
            wr_xfer_d  = 1'b0;
            phase_d    = 1'b0;
            state_d    = ST_IDLE;
            if (start_det) begin
                state_d    = ST_ADDR;
                bit_cnt_d  = '0;
                rx_count_d = '0;
                overflow_d = 1'b0;
            end
        end else begin
            case (state_q)
                ST_IDLE: sda_oe_d = 1'b0;
                ST_ADDR: begin
                    if (scl_rise) begin
                        shift_d   = new_byte[6:0];
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            if (new_byte[7:1] == SLAVE_ADDR) begin
                                state_d   = ST_ADDR_ACK;
                                busy_d    = 1'b1;
                                rw_d      = new_byte[0];
                                wr_xfer_d = (new_byte[0] == RW_WRITE);
                                rd_idx_d  = '0;
                                phase_d   = 1'b0;
                            end else begin
                                state_d = ST_WAIT_STOP;
                            end
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (drive_edge) begin
                        if (!phase_q) begin
                            phase_d  = 1'b1;
                            sda_oe_d = 1'b1;
                        end else begin
                            phase_d = 1'b0;
                            if (rw_q == RW_READ) begin
                                state_d   = ST_RD_DATA;
                                sda_oe_d  = ~tx_byte[7];
                                bit_cnt_d = 4'd1;
                            end else begin
                                state_d   = ST_WR_DATA;
                                sda_oe_d  = 1'b0;
                                bit_cnt_d = '0;
                            end
                        end
                    end
                end
                ST_WR_DATA: begin
                    if (scl_rise) begin
                        shift_d   = new_byte[6:0];
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            state_d = ST_WR_ACK;
                            phase_d = 1'b0;
                            if (wr_in_range && ack_sel) begin
                                for (int i = 0; i < NUM_BYTES; i++) begin
                                    if (wr_hit[i]) rx_data_d[8*i +: 8] = new_byte;
                                end
                                rx_count_d = rx_count_q + CNT_W'(1);
                                ack_drv_d  = 1'b1;
                            end else begin
                                ack_drv_d = 1'b0;
                                if (!wr_in_range) overflow_d = 1'b1;
                            end
                        end
                    end
                end
                ST_WR_ACK: begin
                    if (drive_edge) begin
                        if (!phase_q) begin
                            phase_d  = 1'b1;
                            sda_oe_d = ack_drv_q;
                        end else begin
                            phase_d   = 1'b0;
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = '0;
                            state_d   = ack_drv_q ? ST_WR_DATA : ST_WAIT_STOP;
                        end
                    end
                end
                ST_RD_DATA: begin
                    if (drive_edge) begin
                        if (bit_cnt_q == 4'd8) begin
                            sda_oe_d = 1'b0;
                            state_d  = ST_RD_ACK;
                        end else begin
                            sda_oe_d  = ~tx_byte[3'd7 - bit_cnt_q[2:0]];
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end
                ST_RD_ACK: begin
                    if (scl_rise) begin
                        if (sda_s == I2C_ACK) begin
                            state_d   = ST_RD_DATA;
                            bit_cnt_d = '0;
                            if (rd_idx_q != NUM_BYTES_C) rd_idx_d = rd_idx_q + CNT_W'(1);
                        end else begin
                            state_d = ST_WAIT_STOP;
                        end
                    end
                end
                ST_WAIT_STOP: sda_oe_d = 1'b0;
                default:      state_d  = ST_IDLE;
            endcase
        end
    end

    assign bus.sda_oe = sda_oe_q;
    assign rx_data    = rx_data_q;
    assign rx_count   = rx_count_q;
    assign rx_valid   = rx_valid_q;
    assign busy       = busy_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_i2c_slave_rx_tx.sv
// Directed bench: bit-banged I2C master against the slave, open-drain SDA
// modelled as a wired-AND of the master drive and the slave pull-down.
module tb_i2c_slave_rx_tx;

    localparam int QTR  = 5;
    localparam int HALF = 10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  ack_en;
    logic [15:0] tx_data;
    logic [15:0] rx_data;
    logic [1:0]  rx_count;
    logic        rx_valid, busy, overflow;
    logic        sda_m;

    int n_checks  = 0;
    int n_errors  = 0;
    int oe_cnt    = 0;
    int busy_cnt  = 0;
    int valid_cnt = 0;

    i2c_slave_rx_tx_if bus ();

    assign bus.sda_in = sda_m & ~bus.sda_oe;

    always #5 clk = ~clk;

    i2c_slave_rx_tx #(
        .SLAVE_ADDR  (7'h5B),
        .NUM_BYTES   (2),
        .SYNC_STAGES (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .ack_en   (ack_en),
        .tx_data  (tx_data),
        .rx_data  (rx_data),
        .rx_count (rx_count),
        .rx_valid (rx_valid),
        .busy     (busy),
        .overflow (overflow)
    );

    always @(negedge clk) begin
        if (bus.sda_oe === 1'b1) oe_cnt++;
        if (busy === 1'b1) busy_cnt++;
        if (rx_valid === 1'b1) valid_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic xfer_bit(input logic b, output logic line);
        sda_m = b;
        tick(QTR);
        bus.scl_in = 1'b1;
        tick(HALF);
        line = bus.sda_in;
        bus.scl_in = 1'b0;
        tick(QTR);
    endtask

    task automatic bus_start();
        sda_m = 1'b1;
        bus.scl_in = 1'b1;
        tick(HALF);
        sda_m = 1'b0;
        tick(HALF);
        bus.scl_in = 1'b0;
        tick(QTR);
        $display("txn START");
    endtask

    task automatic bus_rstart();
        sda_m = 1'b1;
        tick(QTR);
        bus.scl_in = 1'b1;
        tick(HALF);
        sda_m = 1'b0;
        tick(HALF);
        bus.scl_in = 1'b0;
        tick(QTR);
        $display("txn Sr");
    endtask

    task automatic bus_stop();
        sda_m = 1'b0;
        tick(QTR);
        bus.scl_in = 1'b1;
        tick(HALF);
        sda_m = 1'b1;
        tick(HALF);
        $display("txn STOP");
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic dummy;
        for (int i = 7; i >= 0; i--) xfer_bit(d[i], dummy);
        xfer_bit(1'b1, ack);
        $display("txn wr 0x%02h ack_line=%0b", d, ack);
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] d);
        logic dummy;
        for (int i = 7; i >= 0; i--) xfer_bit(1'b1, d[i]);
        xfer_bit(mack, dummy);
        $display("txn rd 0x%02h master_ack=%0b", d, mack);
    endtask

    initial begin
        logic       ack;
        logic [7:0] rd;
        logic [7:0] addr_w;
        int         v0, oe0, b0;

        rst_n      = 1'b0;
        bus.scl_in = 1'b1;
        sda_m      = 1'b1;
        ack_en     = 2'b11;
        tx_data    = 16'h0000;
        tick(5);
        check_eq("rst_sda_oe",   bus.sda_oe, 0);
        check_eq("rst_rx_data",  rx_data, 0);
        check_eq("rst_rx_count", rx_count, 0);
        check_eq("rst_rx_valid", rx_valid, 0);
        check_eq("rst_busy",     busy, 0);
        check_eq("rst_overflow", overflow, 0);
        rst_n = 1'b1;
        tick(HALF);

        // Write two bytes, all acknowledged
        v0 = valid_cnt;
        bus_start();
        write_byte(8'hB6, ack); check_eq("w2_addr_ack", ack, 0);
        check_eq("w2_busy", busy, 1);
        write_byte(8'h4C, ack); check_eq("w2_d0_ack", ack, 0);
        write_byte(8'h49, ack); check_eq("w2_d1_ack", ack, 0);
        check_eq("w2_no_valid_early", valid_cnt - v0, 0);
        bus_stop();
        tick(HALF);
        check_eq("w2_rx_data",  rx_data, 16'h494C);
        check_eq("w2_rx_count", rx_count, 2);
        check_eq("w2_valid",    valid_cnt - v0, 1);
        check_eq("w2_busy_end", busy, 0);
        check_eq("w2_overflow", overflow, 0);

        // Address mismatch: bus must never be touched
        v0 = valid_cnt; oe0 = oe_cnt; b0 = busy_cnt;
        bus_start();
        write_byte(8'hB4, ack); check_eq("mm_addr_nack", ack, 1);
        write_byte(8'h77, ack); check_eq("mm_data_nack", ack, 1);
        bus_stop();
        tick(HALF);
        check_eq("mm_oe_never",   oe_cnt - oe0, 0);
        check_eq("mm_busy_never", busy_cnt - b0, 0);
        check_eq("mm_valid",      valid_cnt - v0, 0);
        check_eq("mm_rx_data",    rx_data, 16'h494C);
        check_eq("mm_rx_count",   rx_count, 0);

        // Selective NACK on byte 0
        ack_en = 2'b10;
        v0 = valid_cnt;
        bus_start();
        write_byte(8'hB6, ack); check_eq("sn_addr_ack", ack, 0);
        write_byte(8'h4C, ack); check_eq("sn_data_nack", ack, 1);
        bus_stop();
        tick(HALF);
        check_eq("sn_rx_count", rx_count, 0);
        check_eq("sn_valid",    valid_cnt - v0, 0);
        check_eq("sn_rx_data",  rx_data, 16'h494C);
        check_eq("sn_busy_end", busy, 0);

        // Overflow: third byte exceeds the buffer
        ack_en = 2'b11;
        v0 = valid_cnt;
        bus_start();
        write_byte(8'hB6, ack); check_eq("ov_addr_ack", ack, 0);
        write_byte(8'h11, ack); check_eq("ov_d0_ack", ack, 0);
        write_byte(8'h22, ack); check_eq("ov_d1_ack", ack, 0);
        write_byte(8'h33, ack); check_eq("ov_d2_nack", ack, 1);
        bus_stop();
        tick(HALF);
        check_eq("ov_overflow", overflow, 1);
        check_eq("ov_rx_count", rx_count, 2);
        check_eq("ov_rx_data",  rx_data, 16'h2211);
        check_eq("ov_valid",    valid_cnt - v0, 1);

        // Read behind a repeated START
        tx_data = 16'hA5C3;
        bus_start();
        write_byte(8'hB6, ack); check_eq("rd_waddr_ack", ack, 0);
        v0 = valid_cnt;
        bus_rstart();
        write_byte(8'hB7, ack); check_eq("rd_raddr_ack", ack, 0);
        read_byte(1'b0, rd); check_eq("rd_byte0", rd, 8'hC3);
        read_byte(1'b1, rd); check_eq("rd_byte1", rd, 8'hA5);
        check_eq("rd_released", bus.sda_oe, 0);
        check_eq("rd_busy_held", busy, 1);
        bus_stop();
        tick(HALF);
        check_eq("rd_busy_end", busy, 0);
        check_eq("rd_valid",    valid_cnt - v0, 0);

        // Reset while the address ACK is being driven
        addr_w = 8'hB6;
        bus_start();
        for (int i = 7; i >= 0; i--) xfer_bit(addr_w[i], ack);
        check_eq("mr_oe_driving", bus.sda_oe, 1);
        rst_n = 1'b0;
        tick(1);
        check_eq("mr_oe_released", bus.sda_oe, 0);
        check_eq("mr_busy",        busy, 0);
        check_eq("mr_rx_count",    rx_count, 0);
        check_eq("mr_rx_data",     rx_data, 0);
        check_eq("mr_overflow",    overflow, 0);
        sda_m = 1'b1;
        bus.scl_in = 1'b1;
        tick(3);
        rst_n = 1'b1;
        tick(HALF);
        v0 = valid_cnt;
        bus_start();
        write_byte(8'hB6, ack); check_eq("mr_addr_ack", ack, 0);
        write_byte(8'h4C, ack); check_eq("mr_d0_ack", ack, 0);
        bus_stop();
        tick(HALF);
        check_eq("mr_rx_data_after",  rx_data, 16'h004C);
        check_eq("mr_rx_count_after", rx_count, 1);
        check_eq("mr_valid_after",    valid_cnt - v0, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
